layer_ram_controller: RTL and testbench
=======================================

# layer_ram_controller

Per-layer sequencer that sits directly downstream of the network controller. It starts on the one-cycle start pulse for the selected layer, walks every (neuron, input) pair of that layer, and drives the weight RAM, the activation RAM and the multiply-accumulate unit. After each neuron it writes the MAC result back to the activation RAM. When the layer is complete it returns a one-cycle `done` pulse to the network controller.

## Interface
- `N_IN`, 4: number of network inputs (layer 0 fan-in).
- `N_OUT0`, 4: neurons in layer 0 (layer 1 fan-in).
- `N_OUT1`, 4: neurons in layer 1 (layer 2 fan-in).
- `N_OUT2`, 2: neurons in layer 2 (output layer).
- `NW`, 5: neuron/input index width; every `N_*` ≤ 2^NW − 1.
- `WAW`, 10: weight address width.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs.
- `start`  in  1  one-cycle pulse from the network controller.
- `layer`  in  2  layer to process (0..2), sampled with `start`.
- `done`  out  1  one-cycle pulse when the layer is finished.
- `busy`  out  1  high from the cycle after `start` until the `done` cycle inclusive.
- `w_addr`  out  WAW  weight RAM read address.
- `w_re`  out  1  weight RAM read enable.
- `a_rd_addr`  out  NW+2  activation RAM read address.
- `a_re`  out  1  activation RAM read enable.
- `a_wr_addr`  out  NW+2  activation RAM write address.
- `a_we`  out  1  activation RAM write enable (data path is external: activation(MAC)).
- `mac_clr`  out  1  clear the accumulator.
- `mac_en`  out  1  accumulate `weight × activation` this cycle.
- `mac_bias`  out  1  with `mac_en`, the MAC uses constant 1 in place of the activation.

## Operation
- Activation RAM is organised as banks of 2^NW words; bank b base = b·2^NW. Layer L reads bank L and writes bank L+1. Bank 0 is loaded externally.
- Layer geometry:
  - n_in(0..2) = N_IN, N_OUT0, N_OUT1.
  - n_out(0..2) = N_OUT0, N_OUT1, N_OUT2.
- Weight layout is row-major per neuron, with the bias last.
  - Neuron j, input i of layer L: w_base(L) + j·(n_in+1) + i. Index i = n_in is the bias.
  - w_base(0) = 0; w_base(1) = N_OUT0·(N_IN+1); w_base(2) = w_base(1) + N_OUT1·(N_OUT0+1).
- FSM states:
  - IDLE: wait for `start`. On `start`, latch `layer`, set j=0, go to CLEAR. If the latched layer is 3, go to DONE instead.
  - CLEAR: `mac_clr`=1, i=0 → FETCH.
  - FETCH: `w_re`=1 with `w_addr` = address(j,i).
    - i < n_in: `a_re`=1, `a_rd_addr` = bankL + i.
    - i = n_in (bias): `a_re`=0, the bias flag is set.
    - i increments each cycle. After i = n_in → DRAIN.
  - DRAIN: no reads; the final accumulate happens → WRITE.
  - WRITE: `a_we`=1, `a_wr_addr` = bank(L+1) + j. If j = n_out−1 → DONE, else j+1 → CLEAR.
  - DONE: `done`=1 for one cycle → IDLE.
- `mac_en` and `mac_bias` are the FETCH read-valid and bias flag delayed by one register stage, matching the 1-cycle RAM read latency.
- `start` while not in IDLE is ignored. `layer` is only sampled in IDLE.
- All outputs are zero whenever not listed as asserted. All outputs are 0 in reset.

## Timing
- RAM read latency is exactly 1 cycle. MAC accumulates on the edge at the end of a `mac_en` cycle. MAC output is valid in the WRITE cycle.
- Per neuron: 1 (CLEAR) + n_in+1 (FETCH) + 1 (DRAIN) + 1 (WRITE) = n_in+4 cycles.
- With `start` high at edge 0:
  - CLEAR occupies cycle 1.
  - `done` is high in cycle n_out·(n_in+4)+1.
  - A new `start` is accepted in the cycle after `done`.
- `mac_en` is high for n_in+1 consecutive cycles per neuron: the FETCH span shifted by one cycle. `mac_bias` is high only on the last of these.
- Reset mid-layer: asynchronously returns to IDLE and zeroes counters and outputs. No `done` is produced.
- Counters never wrap: j ≤ n_out−1 and i ≤ n_in by construction.

## Structure
- Shared package `nn_pkg`:
  - FSM state encoding (IDLE, CLEAR, FETCH, DRAIN, WRITE, DONE).
  - Bank-base helper and layer-count constant (3).
- One sub-module, `layer_geometry`: combinational; maps `layer` to n_in, n_out and w_base from the parameters. The top holds the FSM, counters and the read-valid/bias delay registers.

## Test plan
All scenarios use N_IN=2, N_OUT0=2, N_OUT1=2, N_OUT2=1.
- Layer 0, `start` at edge 0:
  - `w_addr` sequence 0,1,2 then 3,4,5.
  - `a_rd_addr` 0,1 per neuron.
  - `a_we` at `a_wr_addr` 64 and 65.
  - `done` in cycle 13 only.
- Layer 2:
  - `w_addr` 12,13,14.
  - `a_rd_addr` 128,129.
  - single write to 192.
  - `done` in cycle 7.
- `mac_en`/`mac_bias` alignment:
  - `mac_en` high exactly one cycle after each `w_re`, 3 cycles per neuron.
  - `mac_bias` high only with the third.
  - `mac_clr` precedes each group.
- `start` pulsed again during layer-1 processing: ignored. Exactly one `done`, and the address trace is unchanged.
- `reset` asserted mid-FETCH of layer 1: all outputs 0 immediately (asynchronous), no `done`. A subsequent `start` with layer 1 runs the full sequence from `w_addr` 6.
- `layer`=3 with `start`: no RAM or MAC activity, `done` in cycle 1.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the layer sequencer: FSM encoding, layer count and
// the activation RAM bank addressing helper.
package nn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FETCH,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } state_e;

  // Number of real layers; a layer select equal to this value is a no-op.
  localparam int N_LAYERS = 3;

  // Base word address of activation bank 'bank' when each bank is 2^nw words.
  function automatic int unsigned bank_base(input logic [1:0] bank, input int unsigned nw);
    return 32'(bank) << nw;
  endfunction

endpackage

// File: rtl/layer_geometry.sv
// Combinational lookup of fan-in, neuron count and weight base for a layer.
module layer_geometry #(
  parameter int N_IN   = 4,
  parameter int N_OUT0 = 4,
  parameter int N_OUT1 = 4,
  parameter int N_OUT2 = 2,
  parameter int NW     = 5,
  parameter int WAW    = 10
) (
  input  logic [1:0]     layer_i,
  output logic [NW-1:0]  n_in_o,
  output logic [NW-1:0]  n_out_o,
  output logic [WAW-1:0] w_base_o
);

  // Each neuron owns n_in weights plus one bias word, stored back to back.
  localparam int W_BASE1 = N_OUT0 * (N_IN + 1);
  localparam int W_BASE2 = W_BASE1 + N_OUT1 * (N_OUT0 + 1);

  // Layer select to geometry; unused select (3) yields an empty layer.
  always_comb begin
    n_in_o   = '0;
    n_out_o  = '0;
    w_base_o = '0;
    case (layer_i)
      2'd0: begin
        n_in_o   = NW'(N_IN);
        n_out_o  = NW'(N_OUT0);
        w_base_o = '0;
      end
      2'd1: begin
        n_in_o   = NW'(N_OUT0);
        n_out_o  = NW'(N_OUT1);
        w_base_o = WAW'(W_BASE1);
      end
      2'd2: begin
        n_in_o   = NW'(N_OUT1);
        n_out_o  = NW'(N_OUT2);
        w_base_o = WAW'(W_BASE2);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/layer_ram_controller.sv
// Per-layer sequencer: walks every (neuron, input) pair of the selected layer,
// drives weight/activation RAM reads and the MAC, writes each neuron result
// back to the next activation bank and pulses done at the end of the layer.
module layer_ram_controller
  import nn_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int N_OUT0 = 4,
  parameter int N_OUT1 = 4,
  parameter int N_OUT2 = 2,
  parameter int NW     = 5,
  parameter int WAW    = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [1:0]     layer,
  output logic           done,
  output logic           busy,
  output logic [WAW-1:0] w_addr,
  output logic           w_re,
  output logic [NW+1:0]  a_rd_addr,
  output logic           a_re,
  output logic [NW+1:0]  a_wr_addr,
  output logic           a_we,
  output logic           mac_clr,
  output logic           mac_en,
  output logic           mac_bias
);

  state_e         state_q, state_d;
  logic [1:0]     layer_q, layer_d;
  logic [NW-1:0]  j_q, j_d;
  logic [NW-1:0]  i_q, i_d;
  logic           mac_en_q, mac_bias_q;
  logic [NW-1:0]  n_in, n_out;
  logic [WAW-1:0] w_base;
  logic           fetch_vld, fetch_bias;

  layer_geometry #(
    .N_IN(N_IN), .N_OUT0(N_OUT0), .N_OUT1(N_OUT1), .N_OUT2(N_OUT2),
    .NW(NW), .WAW(WAW)
  ) u_geom (
    .layer_i (layer_q),
    .n_in_o  (n_in),
    .n_out_o (n_out),
    .w_base_o(w_base)
  );

  // FSM state, latched layer and neuron/input counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      layer_q <= '0;
      j_q     <= '0;
      i_q     <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      j_q     <= j_d;
      i_q     <= i_d;
    end
  end

  // Next-state and counter update; start is only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    j_d     = j_q;
    i_d     = i_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          layer_d = layer;
          j_d     = '0;
          i_d     = '0;
          state_d = (layer == 2'(N_LAYERS)) ? ST_DONE : ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        i_d     = '0;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        // i holds at n_in (the bias slot) so it never wraps.
        if (i_q == n_in) begin
          state_d = ST_DRAIN;
        end else begin
          i_d = i_q + NW'(1);
        end
      end
      ST_DRAIN: state_d = ST_WRITE;
      ST_WRITE: begin
        if (j_q == n_out - NW'(1)) begin
          state_d = ST_DONE;
        end else begin
          j_d     = j_q + NW'(1);
          state_d = ST_CLEAR;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign fetch_vld  = (state_q == ST_FETCH);
  assign fetch_bias = fetch_vld && (i_q == n_in);

  // Delay read-valid and bias flag by the one-cycle RAM read latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mac_en_q   <= 1'b0;
      mac_bias_q <= 1'b0;
    end else begin
      mac_en_q   <= fetch_vld;
      mac_bias_q <= fetch_bias;
    end
  end

  // Output decode from current state; everything not listed stays zero.
  always_comb begin
    done      = 1'b0;
    busy      = (state_q != ST_IDLE);
    w_addr    = '0;
    w_re      = 1'b0;
    a_rd_addr = '0;
    a_re      = 1'b0;
    a_wr_addr = '0;
    a_we      = 1'b0;
    mac_clr   = 1'b0;
    mac_en    = mac_en_q;
    mac_bias  = mac_bias_q;
    case (state_q)
      ST_CLEAR: mac_clr = 1'b1;
      ST_FETCH: begin
        w_re   = 1'b1;
        w_addr = w_base + WAW'(j_q) * (WAW'(n_in) + WAW'(1)) + WAW'(i_q);
        if (i_q < n_in) begin
          a_re      = 1'b1;
          a_rd_addr = (NW+2)'(bank_base(layer_q, NW) + 32'(i_q));
        end
      end
      ST_WRITE: begin
        a_we      = 1'b1;
        a_wr_addr = (NW+2)'(bank_base(layer_q + 2'd1, NW) + 32'(j_q));
      end
      ST_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_layer_ram_controller.sv
module tb_layer_ram_controller;

  localparam int NW  = 6;
  localparam int WAW = 10;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [1:0]     layer;
  logic           done, busy, w_re, a_re, a_we, mac_clr, mac_en, mac_bias;
  logic [WAW-1:0] w_addr;
  logic [NW+1:0]  a_rd_addr, a_wr_addr;

  int checks = 0;
  int failures = 0;

  int wq[$], rq[$], wrq[$], doneq[$], biasq[$], clrq[$];
  int en_cnt, busy_cnt, align_err;

  layer_ram_controller #(
    .N_IN(2), .N_OUT0(2), .N_OUT1(2), .N_OUT2(1), .NW(NW), .WAW(WAW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .layer(layer),
    .done(done), .busy(busy), .w_addr(w_addr), .w_re(w_re),
    .a_rd_addr(a_rd_addr), .a_re(a_re), .a_wr_addr(a_wr_addr), .a_we(a_we),
    .mac_clr(mac_clr), .mac_en(mac_en), .mac_bias(mac_bias)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag, input int q[$], input int exp[$]);
    chk({tag, "_len"}, q.size(), exp.size());
    for (int k = 0; k < exp.size() && k < q.size(); k++)
      chk($sformatf("%s[%0d]", tag, k), q[k], exp[k]);
  endtask

  function automatic logic [31:0] all_outs();
    return {done, busy, w_addr, w_re, a_rd_addr, a_re, a_wr_addr, a_we,
            mac_clr, mac_en, mac_bias};
  endfunction

  // Starts layer L at the next edge (edge 0) and records 20 cycles of activity.
  // A second start pulse with extra_layer is driven in cycle extra_cyc (0 = none).
  task automatic run_layer(input logic [1:0] L, input int extra_cyc, input logic [1:0] extra_layer);
    logic prev_wre, prev_bias;
    wq.delete(); rq.delete(); wrq.delete(); doneq.delete(); biasq.delete(); clrq.delete();
    en_cnt = 0; busy_cnt = 0; align_err = 0;
    prev_wre = 1'b0; prev_bias = 1'b0;
    start = 1'b1; layer = L;
    @(posedge clk);
    #1 start = 1'b0; layer = 2'd0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (w_re)     wq.push_back(int'(w_addr));
      if (a_re)     rq.push_back(int'(a_rd_addr));
      if (a_we)     wrq.push_back(int'(a_wr_addr));
      if (done)     doneq.push_back(c);
      if (mac_bias) biasq.push_back(c);
      if (mac_clr)  clrq.push_back(c);
      if (mac_en)   en_cnt++;
      if (busy)     busy_cnt++;
      if (mac_en !== prev_wre)    align_err++;
      if (mac_bias !== prev_bias) align_err++;
      prev_wre  = w_re;
      prev_bias = w_re && !a_re;
      if (c == extra_cyc) begin
        start = 1'b1; layer = extra_layer;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  initial begin
    int dn;
    reset = 1'b1; start = 1'b0; layer = 2'd0;
    repeat (2) @(negedge clk);
    chk("reset_outputs_zero", all_outs(), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_outputs_zero", all_outs(), 0);

    // Layer 0: two neurons of fan-in 2
    run_layer(2'd0, 0, 2'd0);
    chk_q("l0_waddr", wq, '{0, 1, 2, 3, 4, 5});
    chk_q("l0_rdaddr", rq, '{0, 1, 0, 1});
    chk_q("l0_wraddr", wrq, '{64, 65});
    chk_q("l0_done", doneq, '{13});
    chk_q("l0_bias_cycles", biasq, '{5, 11});
    chk_q("l0_clr_cycles", clrq, '{1, 7});
    chk("l0_mac_en_cnt", en_cnt, 6);
    chk("l0_busy_cnt", busy_cnt, 13);
    chk("l0_mac_align", align_err, 0);
    chk("l0_idle_after", all_outs(), 0);

    // Layer 2: single output neuron
    run_layer(2'd2, 0, 2'd0);
    chk_q("l2_waddr", wq, '{12, 13, 14});
    chk_q("l2_rdaddr", rq, '{128, 129});
    chk_q("l2_wraddr", wrq, '{192});
    chk_q("l2_done", doneq, '{7});
    chk_q("l2_bias_cycles", biasq, '{5});
    chk("l2_mac_en_cnt", en_cnt, 3);
    chk("l2_mac_align", align_err, 0);

    // Layer 1 with a stray start (selecting layer 0) mid-layer
    run_layer(2'd1, 4, 2'd0);
    chk_q("l1_waddr", wq, '{6, 7, 8, 9, 10, 11});
    chk_q("l1_rdaddr", rq, '{64, 65, 64, 65});
    chk_q("l1_wraddr", wrq, '{128, 129});
    chk_q("l1_done", doneq, '{13});
    chk("l1_mac_align", align_err, 0);

    // Layer select 3: immediate done, no RAM or MAC activity
    run_layer(2'd3, 0, 2'd0);
    chk("l3_w_reads", wq.size(), 0);
    chk("l3_a_reads", rq.size(), 0);
    chk("l3_writes", wrq.size(), 0);
    chk("l3_clr", clrq.size(), 0);
    chk("l3_mac_en", en_cnt, 0);
    chk_q("l3_done", doneq, '{1});

    // Asynchronous reset in the middle of layer 1 FETCH
    start = 1'b1; layer = 2'd1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pre_wre", w_re, 1);
    chk("rst_pre_waddr", w_addr, 7);
    chk("rst_pre_mac_en", mac_en, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_zero", all_outs(), 0);
    chk("rst_async_mac_en", mac_en, 0);
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dn++;
    end
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    chk("rst_no_done", dn, 0);

    run_layer(2'd1, 0, 2'd0);
    chk_q("rst_l1_waddr", wq, '{6, 7, 8, 9, 10, 11});
    chk_q("rst_l1_wraddr", wrq, '{128, 129});
    chk_q("rst_l1_done", doneq, '{13});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
